// File: rtl/and_vector_seq.sv
// ============================================================================
// Module   : and_vector_seq
// Brief    : Drives x,y through 00,01,10,11 into a 2-input AND gate, checks z.
//            Optional first-failure capture ports via FAIL_CAPTURE_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module and_vector_seq #(
    parameter int HOLD_CYCLES = 10,
    parameter int LOOPS       = 1,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             x_o,
    output logic             y_o,
    input  logic             z_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [1:0]       vec_idx_o
`ifdef FAIL_CAPTURE_EN
    ,
    output logic             fail_valid_o,
    output logic [1:0]       fail_vec_o
`endif
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_LOOP_W-1:0] c_LOOP_LAST = c_LOOP_W'(LOOPS - 1);
    localparam logic [ERR_W-1:0]    c_ERR_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic                x_q;
    logic                y_q;
    logic                busy_q;
    logic                done_q;
    logic [1:0]          vec_q;
    logic [c_HOLD_W-1:0] hold_q;
    logic [c_LOOP_W-1:0] loop_q;
    logic [ERR_W-1:0]    err_q;

    logic                w_start;
    logic                w_sample;
    logic                w_mismatch;
    logic                w_last;
    logic [1:0]          vec_d;
    logic [ERR_W-1:0]    err_d;

    // z has had HOLD_CYCLES-1 cycles to settle by the sample edge
    assign w_start    = start_i && (state_q != S_RUN);
    assign w_sample   = (state_q == S_RUN) && (hold_q == c_HOLD_LAST);
    assign w_mismatch = w_sample && (z_i != (x_q & y_q));
    assign w_last     = (vec_q == 2'd3) && (loop_q == c_LOOP_LAST);
    assign vec_d      = vec_q + 2'd1;
    assign err_d      = (w_mismatch && (err_q != c_ERR_MAX)) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vec_q   <= 2'd0;
            hold_q  <= '0;
            loop_q  <= '0;
            err_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        x_q     <= 1'b0;
                        y_q     <= 1'b0;
                        vec_q   <= 2'd0;
                        hold_q  <= '0;
                        loop_q  <= '0;
                        err_q   <= '0;
                    end
                end
                S_RUN: begin
                    err_q <= err_d;
                    if (w_sample) begin
                        hold_q <= '0;
                        if (w_last) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            x_q     <= 1'b0;
                            y_q     <= 1'b0;
                            vec_q   <= 2'd0;
                            loop_q  <= '0;
                        end else begin
                            vec_q <= vec_d;
                            x_q   <= vec_d[1];
                            y_q   <= vec_d[0];
                            if (vec_q == 2'd3) begin
                                loop_q <= loop_q + 1'b1;
                            end
                        end
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FAIL_CAPTURE_EN
    logic       fail_valid_q;
    logic [1:0] fail_vec_q;

    // Only the first mismatch of a run is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
        end else if (w_start) begin
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
        end else if (w_mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
        end
    end

    assign fail_valid_o = fail_valid_q;
    assign fail_vec_o   = fail_vec_q;
`endif

    assign x_o       = x_q;
    assign y_o       = y_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign pass_o    = done_q && (err_q == '0);
    assign err_cnt_o = err_q;
    assign vec_idx_o = vec_q;

endmodule

`default_nettype wire

// File: tb/tb_and_vector_seq.sv
// ============================================================================
// Module   : tb_and_vector_seq
// Brief    : Directed bench for and_vector_seq with a modelled and_db gate.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_and_vector_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       x, y, z;
    logic       busy, done, pass;
    logic [3:0] err;
    logic [1:0] vec;
    logic [1:0] mode;

    logic       start8;
    logic       x8, y8, z8;
    logic       busy8, done8, pass8;
    logic [3:0] err8;
    logic [1:0] vec8;
    logic [1:0] mode8;

`ifdef FAIL_CAPTURE_EN
    logic       fv, fv8;
    logic [1:0] fvec, fvec8;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Gate model: 0 = good AND, 1 = OR, 2 = stuck at 1
    assign z  = (mode  == 2'd0) ? (x & y)   : (mode  == 2'd1) ? (x | y)   : 1'b1;
    assign z8 = (mode8 == 2'd0) ? (x8 & y8) : (mode8 == 2'd1) ? (x8 | y8) : 1'b1;

    and_vector_seq #(.HOLD_CYCLES(10), .LOOPS(1), .ERR_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .x_o       (x),
        .y_o       (y),
        .z_i       (z),
        .busy_o    (busy),
        .done_o    (done),
        .pass_o    (pass),
        .err_cnt_o (err),
        .vec_idx_o (vec)
`ifdef FAIL_CAPTURE_EN
        ,
        .fail_valid_o (fv),
        .fail_vec_o   (fvec)
`endif
    );

    and_vector_seq #(.HOLD_CYCLES(10), .LOOPS(8), .ERR_W(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start8),
        .x_o       (x8),
        .y_o       (y8),
        .z_i       (z8),
        .busy_o    (busy8),
        .done_o    (done8),
        .pass_o    (pass8),
        .err_cnt_o (err8),
        .vec_idx_o (vec8)
`ifdef FAIL_CAPTURE_EN
        ,
        .fail_valid_o (fv8),
        .fail_vec_o   (fvec8)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {busy,done,vec,x,y} packed for per-cycle checks
    task automatic do_run(input logic keep_start, input int exp_err,
                          input logic exp_fv, input logic [1:0] exp_fvec);
        logic [1:0] v;
        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        chk("start_state", {busy, done, pass, vec, x, y}, {1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0});
        chk("start_err_clr", err, 0);
`ifdef FAIL_CAPTURE_EN
        chk("start_fv_clr", {fv, fvec}, 3'b000);
`endif
        for (int n = 1; n < 40; n++) begin
            tick();
            v = 2'(n / 10);
            chk("run_seq", {busy, done, vec, x, y}, {1'b1, 1'b0, v, v[1], v[0]});
        end
        tick();
        start = 1'b0;
        chk("done_flags", {busy, done, vec, x, y}, {1'b0, 1'b1, 2'd0, 1'b0, 1'b0});
        chk("done_err", err, exp_err);
        chk("done_pass", pass, (exp_err == 0));
`ifdef FAIL_CAPTURE_EN
        chk("done_fail_cap", {fv, fvec}, {exp_fv, exp_fvec});
`endif
        tick();
        chk("done_hold", {busy, done, err}, {1'b0, 1'b1, 4'(exp_err)});
    endtask

    initial begin
        int cyc;
        rst    = 1'b1;
        start  = 1'b0;
        start8 = 1'b0;
        mode   = 2'd0;
        mode8  = 2'd0;
        tick();
        tick();
        chk("reset_state", {busy, done, pass, vec, x, y}, 7'd0);
        chk("reset_err", err, 0);
`ifdef FAIL_CAPTURE_EN
        chk("reset_fv", {fv, fvec}, 3'b000);
`endif
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {busy, done, x, y}, 4'd0);

        // Good gate, single pulse
        mode = 2'd0;
        do_run(1'b0, 0, 1'b0, 2'd0);

        // OR gate: vectors 01 and 10 mismatch
        mode = 2'd1;
        do_run(1'b0, 2, 1'b1, 2'd1);

        // Restart from DONE with good gate clears the count
        mode = 2'd0;
        do_run(1'b0, 0, 1'b0, 2'd0);

        // start held high for the whole run
        do_run(1'b1, 0, 1'b0, 2'd0);

        // Abort during vector 2 with an error already counted
        mode  = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n <= 25; n++) tick();
        chk("mid_run_vec", {busy, vec, x, y}, {1'b1, 2'd2, 1'b1, 1'b0});
        chk("mid_run_err", err, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", {busy, done, pass, vec, x, y}, 7'd0);
        chk("async_rst_err", err, 0);
`ifdef FAIL_CAPTURE_EN
        chk("async_rst_fv", {fv, fvec}, 3'b000);
`endif
        tick();
        rst  = 1'b0;
        tick();
        chk("post_abort_idle", {busy, done, pass}, 3'd0);
        mode = 2'd0;
        do_run(1'b0, 0, 1'b0, 2'd0);

        // Stuck-at-1, 8 loops: 24 mismatches saturate at 15
        mode8  = 2'd2;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc    = 0;
        while (!done8 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("sat_run_len", cyc, 320);
        chk("sat_err", err8, 15);
        chk("sat_flags", {busy8, done8, pass8, vec8, x8, y8}, {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
`ifdef FAIL_CAPTURE_EN
        chk("sat_fail_cap", {fv8, fvec8}, {1'b1, 2'd0});
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
